mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller serving the CPU's two memory ports: instruction fetch (read-only) and data (read/write, byte enables).
- Sits between the CPU core and one external asynchronous 16-bit SRAM.
- Arbitrates between the ports, splits each 32-bit word access into two half-word SRAM cycles with programmable wait states, and returns a one-cycle ready pulse per completed access.

Parameters:
- ADDR_W, 18: SRAM half-word address width.
- WAIT_CYCLES, 1: cycles each half-word access holds SRAM controls; minimum 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_mc_en  in  1  fetch request, level; held until mc_if_ready.
- if_mc_addr  in  32  fetch byte address; bits [1:0] ignored.
- mc_if_data  out  32  fetched word, registered; held until the next fetch completes.
- mc_if_ready  out  1  one-cycle pulse: fetch complete.
- mem_mc_rw  in  1  1 = read, 0 = write.
- mem_mc_en  in  1  data request, level; held until mc_mem_ready.
- mem_mc_addr  in  32  data byte address; bits [1:0] ignored.
- mem_mc_data  inout  32  write data from core; controller drives read word when mem_mc_en=1 and mem_mc_rw=1, else Z.
- mem_mc_en1h / mem_mc_en1l / mem_mc_en2h / mem_mc_en2l  in  1 each  byte enables for bits [15:8] / [7:0] / [31:24] / [23:16].
- mc_mem_ready  out  1  one-cycle pulse: data access complete.
- sram_addr  out  ADDR_W  half-word address = {addr[ADDR_W:2], half}, half 0 = bits [15:0].
- sram_data  inout  16  SRAM data; driven only during write states.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM controls.

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - All sram_*_n = 1; sram_addr = 0; sram_data Z.
  - mc_if_data = 0; both ready pulses = 0; wait counter = 0; mem_mc_data Z.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - mem_mc_en=1 takes priority over if_mc_en=1.
  - Latch port select, word address, rw, byte enables and write data, then go to LO.
  - If neither request is high, stay in IDLE.
- LO / HI:
  - Each state asserts ce_n=0 and the proper address for exactly WAIT_CYCLES cycles, then advances LO→HI→DONE.
  - Read: oe_n=0, ub_n=lb_n=0; SRAM data captured on the last cycle of the state into the low or high half of the data register.
  - Write: oe_n=1; ub_n/lb_n = inverted en1h/en1l in LO and inverted en2h/en2l in HI; sram_data driven; we_n=0 for the whole state.
  - A write half whose two enables are both 0 is skipped: state lasts 1 cycle with ce_n=1.
- DONE:
  - Pulse the ready output of the served port for 1 cycle.
  - Fetch: mc_if_data updated at entry to DONE.
  - Data read: read word registered; visible on mem_mc_data while the request is held.
  - Next state IDLE.
- Latency: request sampled in IDLE at edge k; ready high in cycle k + 2·WAIT_CYCLES + 1. With WAIT_CYCLES=1 that is 3 cycles after sampling; throughput is 1 word per 2·WAIT_CYCLES+2 cycles.
- Requests are levels. A request still high in the IDLE after DONE is served again, so the requester must drop or change it on ready.
- Requester drops en mid-access: the access completes, the ready pulse is still issued, and no abort occurs.
- Simultaneous requests: data served first; fetch waits, and is served on the next IDLE if still high.
- Reset mid-access: immediate IDLE; a write half in progress is truncated by we_n rising.

Optional Feature:
- MC_FETCH_BUFFER_EN defined:
  - One-entry fetch buffer holds the last fetched word address and data, with a valid bit.
  - A fetch in IDLE that hits a valid entry goes straight to DONE: ready in cycle k+1, no SRAM cycle.
  - Any data write to that word clears valid; reset clears valid.
  - Data requests still take priority.
- Undefined: no buffer; every fetch goes to SRAM.

Decomposition:
- Package mc_pkg:
  - state encoding (IDLE/LO/HI/DONE)
  - RW_READ=1 / RW_WRITE=0
  - PORT_IF / PORT_MEM select
  - HALF_LO / HALF_HI
- One sub-module, mc_sram_seq:
  - wait-state counter and SRAM control/data drive for a single half-word cycle.
  - Inputs: start, rw, half, ub/lb enables, wdata16. Outputs: done, rdata16.
- mem_ctrl holds the arbiter, FSM and the register file of latched request fields.

Test Plan:
- Fetch 0x0000_0010, SRAM half 8 = 0x5678, half 9 = 0x1234, WAIT_CYCLES=1 → sram_addr 8 then 9, oe_n low 2 cycles, mc_if_ready 3 cycles after sampling, mc_if_data = 0x1234_5678.
- Data write 0xAABB_CCDD to 0x20 with only en2h=1 → LO skipped with ce_n=1; HI writes 0xAABB to half 0x11 with ub_n=0, lb_n=1; SRAM half 0x10 unchanged.
- Fetch and data read asserted in the same cycle → data served first (mc_mem_ready), fetch served next, mc_if_ready 4 cycles after mc_mem_ready.
- WAIT_CYCLES=3 data read → each half holds ce_n/oe_n low 3 cycles; ready 7 cycles after sampling.
- reset pulled low mid-HI of a write → we_n/ce_n high asynchronously, state IDLE, no ready pulse; normal fetch succeeds after release.
- MC_FETCH_BUFFER_EN: fetch 0x40 twice → second ready 1 cycle after sampling, no ce_n activity. Then write 0x40 and fetch 0x40 → full SRAM access returns the new data.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types for the dual-port SRAM memory controller.
// Optional one-entry fetch buffer is enabled with MC_FETCH_BUFFER_EN.
package mc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } mc_state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic PORT_IF  = 1'b0;
    localparam logic PORT_MEM = 1'b1;

    localparam logic HALF_LO  = 1'b0;
    localparam logic HALF_HI  = 1'b1;

    // be order: {en2h, en2l, en1h, en1l}
    typedef struct packed {
        logic        port;
        logic        rw;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mc_req_t;

    function automatic logic half_skipped(logic rw, logic ub, logic lb);
        return (rw == RW_WRITE) && !ub && !lb;
    endfunction

endpackage

// File: rtl/mc_sram_seq.sv
// One half-word SRAM cycle: wait-state counter plus registered SRAM strobes.
// Part of mem_ctrl; fetch buffer option MC_FETCH_BUFFER_EN lives in the top.
module mc_sram_seq
    import mc_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    input  logic              rw_i,
    input  logic              half_i,
    input  logic [ADDR_W-2:0] waddr_i,
    input  logic              ub_en_i,
    input  logic              lb_en_i,
    input  logic [15:0]       wdata16_i,
    output logic              done_o,
    output logic [15:0]       rdata16_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [15:0]       sram_data_io,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic              sram_ub_n_o,
    output logic              sram_lb_n_o
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic              active_q;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ce_n_q;
    logic              oe_n_q;
    logic              we_n_q;
    logic              ub_n_q;
    logic              lb_n_q;
    logic              drive_q;
    logic [15:0]       wdata_q;
    logic              skip;
    logic              rd;

    assign skip = half_skipped(rw_i, ub_en_i, lb_en_i);
    assign rd   = (rw_i == RW_READ);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            drive_q  <= 1'b0;
            wdata_q  <= '0;
        end else if (start_i) begin
            // A skipped write half burns one cycle with the chip deselected
            active_q <= 1'b1;
            cnt_q    <= skip ? '0 : CW'(WAIT_CYCLES - 1);
            addr_q   <= {waddr_i, half_i};
            ce_n_q   <= skip;
            oe_n_q   <= !rd;
            we_n_q   <= rd || skip;
            ub_n_q   <= rd ? 1'b0 : !ub_en_i;
            lb_n_q   <= rd ? 1'b0 : !lb_en_i;
            drive_q  <= !rd && !skip;
            wdata_q  <= wdata16_i;
        end else if (done_o) begin
            active_q <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            drive_q  <= 1'b0;
        end else if (active_q) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o       = active_q && (cnt_q == '0);
    assign rdata16_o    = sram_data_io;
    assign sram_data_io = drive_q ? wdata_q : 16'hzzzz;
    assign sram_addr_o  = addr_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_ub_n_o  = ub_n_q;
    assign sram_lb_n_o  = lb_n_q;

endmodule

// File: rtl/mem_ctrl.sv
// Fetch/data port arbiter and word FSM in front of a 16-bit async SRAM.
// Define MC_FETCH_BUFFER_EN to add a one-entry fetch buffer.
module mem_ctrl
    import mc_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_mc_en,
    input  logic [31:0]       if_mc_addr,
    output logic [31:0]       mc_if_data,
    output logic              mc_if_ready,
    input  logic              mem_mc_rw,
    input  logic              mem_mc_en,
    input  logic [31:0]       mem_mc_addr,
    inout  wire  [31:0]       mem_mc_data,
    input  logic              mem_mc_en1h,
    input  logic              mem_mc_en1l,
    input  logic              mem_mc_en2h,
    input  logic              mem_mc_en2l,
    output logic              mc_mem_ready,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [15:0]       sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam int WA_W = ADDR_W - 1;

    mc_state_e       state_q;
    mc_req_t         req_q;
    mc_req_t         new_req;
    logic [WA_W-1:0] waddr_q;
    logic [WA_W-1:0] new_waddr;
    logic [15:0]     lo_q;
    logic [31:0]     if_data_q;
    logic [31:0]     mem_rdata_q;
    logic            if_ready_q;
    logic            mem_ready_q;
    logic            any_req;
    logic            hit;
    logic [31:0]     buf_word;

    logic            seq_start;
    logic            seq_rw;
    logic            seq_half;
    logic            seq_ub;
    logic            seq_lb;
    logic            seq_done;
    logic [WA_W-1:0] seq_waddr;
    logic [15:0]     seq_wdata;
    logic [15:0]     rdata16;

    assign any_req   = mem_mc_en | if_mc_en;
    assign new_waddr = mem_mc_en ? mem_mc_addr[ADDR_W:2]
                                 : if_mc_addr[ADDR_W:2];

    // Data port wins any tie
    always_comb begin
        new_req       = '0;
        new_req.port  = mem_mc_en ? PORT_MEM : PORT_IF;
        new_req.rw    = mem_mc_en ? mem_mc_rw : RW_READ;
        new_req.be    = {mem_mc_en2h, mem_mc_en2l,
                         mem_mc_en1h, mem_mc_en1l};
        new_req.wdata = mem_mc_data;
    end

`ifdef MC_FETCH_BUFFER_EN
    logic            buf_valid_q;
    logic [WA_W-1:0] buf_addr_q;
    logic [31:0]     buf_data_q;

    assign hit      = !mem_mc_en && if_mc_en && buf_valid_q
                      && (buf_addr_q == if_mc_addr[ADDR_W:2]);
    assign buf_word = buf_data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else if (state_q == IDLE && mem_mc_en
                     && mem_mc_rw == RW_WRITE
                     && mem_mc_addr[ADDR_W:2] == buf_addr_q) begin
            buf_valid_q <= 1'b0;
        end else if (state_q == HI && seq_done
                     && req_q.port == PORT_IF) begin
            buf_valid_q <= 1'b1;
            buf_addr_q  <= waddr_q;
            buf_data_q  <= {rdata16, lo_q};
        end
    end
`else
    assign hit      = 1'b0;
    assign buf_word = '0;
`endif

    always_comb begin
        seq_start = 1'b0;
        seq_rw    = req_q.rw;
        seq_half  = HALF_HI;
        seq_waddr = waddr_q;
        seq_ub    = req_q.be[3];
        seq_lb    = req_q.be[2];
        seq_wdata = req_q.wdata[31:16];
        case (state_q)
            IDLE: begin
                seq_start = any_req && !hit;
                seq_rw    = new_req.rw;
                seq_half  = HALF_LO;
                seq_waddr = new_waddr;
                seq_ub    = new_req.be[1];
                seq_lb    = new_req.be[0];
                seq_wdata = new_req.wdata[15:0];
            end
            LO:      seq_start = seq_done;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            waddr_q     <= '0;
            lo_q        <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (any_req) begin
                    req_q   <= new_req;
                    waddr_q <= new_waddr;
                    if (hit) begin
                        state_q    <= DONE;
                        if_data_q  <= buf_word;
                        if_ready_q <= 1'b1;
                    end else begin
                        state_q <= LO;
                    end
                end
                LO: if (seq_done) begin
                    if (req_q.rw == RW_READ) lo_q <= rdata16;
                    state_q <= HI;
                end
                HI: if (seq_done) begin
                    state_q <= DONE;
                    if (req_q.port == PORT_IF) begin
                        if_data_q  <= {rdata16, lo_q};
                        if_ready_q <= 1'b1;
                    end else begin
                        mem_ready_q <= 1'b1;
                        if (req_q.rw == RW_READ)
                            mem_rdata_q <= {rdata16, lo_q};
                    end
                end
                DONE: begin
                    if_ready_q  <= 1'b0;
                    mem_ready_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mc_sram_seq #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_seq (
        .clock        (clock),
        .reset        (reset),
        .start_i      (seq_start),
        .rw_i         (seq_rw),
        .half_i       (seq_half),
        .waddr_i      (seq_waddr),
        .ub_en_i      (seq_ub),
        .lb_en_i      (seq_lb),
        .wdata16_i    (seq_wdata),
        .done_o       (seq_done),
        .rdata16_o    (rdata16),
        .sram_addr_o  (sram_addr),
        .sram_data_io (sram_data),
        .sram_ce_n_o  (sram_ce_n),
        .sram_oe_n_o  (sram_oe_n),
        .sram_we_n_o  (sram_we_n),
        .sram_ub_n_o  (sram_ub_n),
        .sram_lb_n_o  (sram_lb_n)
    );

    assign mc_if_data   = if_data_q;
    assign mc_if_ready  = if_ready_q;
    assign mc_mem_ready = mem_ready_q;
    assign mem_mc_data  = (mem_mc_en && mem_mc_rw == RW_READ)
                          ? mem_rdata_q : 32'hzzzz_zzzz;

    logic unused_bits;
    assign unused_bits = ^{if_mc_addr[31:ADDR_W+1], if_mc_addr[1:0],
                           mem_mc_addr[31:ADDR_W+1], mem_mc_addr[1:0],
                           req_q.be[1:0], req_q.wdata[15:0]};

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed vector bench for mem_ctrl with a behavioural 16-bit SRAM.
// Fetch-buffer expectations follow MC_FETCH_BUFFER_EN.
`timescale 1ns/1ps
module tb_mem_ctrl;

`ifdef MC_FETCH_BUFFER_EN
    localparam int HIT_LAT = 1;
    localparam int HIT_CE  = 0;
`else
    localparam int HIT_LAT = 3;
    localparam int HIT_CE  = 2;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        if_mc_en = 1'b0;
    logic [31:0] if_mc_addr = '0;
    logic        mem_mc_rw = 1'b1;
    logic        mem_mc_en = 1'b0;
    logic [31:0] mem_mc_addr = '0;
    logic [31:0] tb_wd = '0;
    logic        en1h = 1'b0, en1l = 1'b0, en2h = 1'b0, en2l = 1'b0;
    wire  [31:0] mc_if_data;
    wire         mc_if_ready;
    wire         mc_mem_ready;
    wire  [31:0] mem_mc_data;
    wire  [17:0] sram_addr;
    wire  [15:0] sram_data;
    wire         ce_n, oe_n, we_n, ub_n, lb_n;

    assign mem_mc_data = (mem_mc_en && !mem_mc_rw) ? tb_wd : 32'hzzzz_zzzz;

    mem_ctrl #(.ADDR_W(18), .WAIT_CYCLES(1)) u_dut (
        .clock(clock), .reset(reset),
        .if_mc_en(if_mc_en), .if_mc_addr(if_mc_addr),
        .mc_if_data(mc_if_data), .mc_if_ready(mc_if_ready),
        .mem_mc_rw(mem_mc_rw), .mem_mc_en(mem_mc_en),
        .mem_mc_addr(mem_mc_addr), .mem_mc_data(mem_mc_data),
        .mem_mc_en1h(en1h), .mem_mc_en1l(en1l),
        .mem_mc_en2h(en2h), .mem_mc_en2l(en2l),
        .mc_mem_ready(mc_mem_ready),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
        .sram_ub_n(ub_n), .sram_lb_n(lb_n)
    );

    logic [15:0] sram_mem [256];
    logic        sram_init = 1'b1;

    function automatic logic [15:0] init_val(int i);
        case (i)
            8:       return 16'h5678;
            9:       return 16'h1234;
            16:      return 16'h1111;
            17:      return 16'h2222;
            32:      return 16'h4444;
            33:      return 16'h3333;
            default: return 16'(i * 257);
        endcase
    endfunction

    always @(posedge clock) begin
        if (sram_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
        end else if (!ce_n && !we_n) begin
            if (!ub_n) sram_mem[sram_addr[7:0]][15:8] <= sram_data[15:8];
            if (!lb_n) sram_mem[sram_addr[7:0]][7:0]  <= sram_data[7:0];
        end
    end
    assign sram_data = (!ce_n && !oe_n && we_n)
                       ? sram_mem[sram_addr[7:0]] : 16'hzzzz;

    // Second instance with three wait states and a read-only pattern SRAM
    logic        d3_en = 1'b0;
    logic [31:0] d3_addr_in = '0;
    wire  [31:0] d3_if_data, d3_mem_data;
    wire         d3_if_ready, d3_mem_ready;
    wire  [17:0] d3_addr;
    wire  [15:0] d3_sdata;
    wire         d3_ce, d3_oe, d3_we, d3_ub, d3_lb;

    assign d3_sdata = (!d3_ce && !d3_oe) ? (d3_addr[15:0] ^ 16'h1357) : 16'hzzzz;

    mem_ctrl #(.ADDR_W(18), .WAIT_CYCLES(3)) u_dut3 (
        .clock(clock), .reset(reset),
        .if_mc_en(1'b0), .if_mc_addr(32'h0),
        .mc_if_data(d3_if_data), .mc_if_ready(d3_if_ready),
        .mem_mc_rw(1'b1), .mem_mc_en(d3_en),
        .mem_mc_addr(d3_addr_in), .mem_mc_data(d3_mem_data),
        .mem_mc_en1h(1'b1), .mem_mc_en1l(1'b1),
        .mem_mc_en2h(1'b1), .mem_mc_en2l(1'b1),
        .mc_mem_ready(d3_mem_ready),
        .sram_addr(d3_addr), .sram_data(d3_sdata),
        .sram_ce_n(d3_ce), .sram_oe_n(d3_oe), .sram_we_n(d3_we),
        .sram_ub_n(d3_ub), .sram_lb_n(d3_lb)
    );

    wire unused_tb = ^{sram_addr[17:8], d3_if_data, d3_if_ready,
                       d3_addr[17:16], d3_we, d3_ub, d3_lb};

    int n_cmp  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_mem;
        logic        rw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_ce;
        int          exp_we;
    } vec_t;

    task automatic run_req(input vec_t v, input string tag);
        int          lat;
        int          ce_cnt;
        int          we_cnt;
        logic        seen;
        logic [31:0] rd;
        @(negedge clock);
        if (v.is_mem) begin
            mem_mc_en = 1'b1;
            mem_mc_rw = v.rw;
            mem_mc_addr = v.addr;
            {en2h, en2l, en1h, en1l} = v.be;
            tb_wd = v.wd;
        end else begin
            if_mc_en = 1'b1;
            if_mc_addr = v.addr;
        end
        lat = 0;
        ce_cnt = 0;
        we_cnt = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
            if (!ce_n) ce_cnt++;
            if (!we_n) we_cnt++;
            seen = v.is_mem ? mc_mem_ready : mc_if_ready;
        end
        rd = v.is_mem ? mem_mc_data : mc_if_data;
        mem_mc_en = 1'b0;
        if_mc_en = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_ce"}, 32'(ce_cnt), 32'(v.exp_ce));
        check({tag, "_we"}, 32'(we_cnt), 32'(v.exp_we));
        if (!v.is_mem || v.rw) check({tag, "_data"}, rd, v.exp_rd);
        @(posedge clock);
    endtask

    vec_t        vt[14];
    vec_t        vf;
    int          t;
    int          tm;
    int          ti;
    int          n_oe;
    logic        got_m;
    logic        got_i;
    logic        seen;
    logic [31:0] rd_m;
    logic [31:0] rd_i;

    initial begin
        //        mem   rw    addr          be       wd            exp_rd       lat      ce      we
        vt[0]  = '{1'b0, 1'b1, 32'h10, 4'b0000, 32'h0,        32'h12345678, 3,       2,      0};
        vt[1]  = '{1'b1, 1'b1, 32'h13, 4'b0000, 32'h0,        32'h12345678, 3,       2,      0};
        vt[2]  = '{1'b1, 1'b0, 32'h20, 4'b1000, 32'hAABBCCDD, 32'h0,        3,       1,      1};
        vt[3]  = '{1'b1, 1'b1, 32'h20, 4'b0000, 32'h0,        32'hAA221111, 3,       2,      0};
        vt[4]  = '{1'b1, 1'b0, 32'h30, 4'b1111, 32'hDEADBEEF, 32'h0,        3,       2,      2};
        vt[5]  = '{1'b1, 1'b1, 32'h30, 4'b0000, 32'h0,        32'hDEADBEEF, 3,       2,      0};
        vt[6]  = '{1'b1, 1'b0, 32'h30, 4'b0101, 32'h01020304, 32'h0,        3,       2,      2};
        vt[7]  = '{1'b1, 1'b1, 32'h32, 4'b0000, 32'h0,        32'hDE02BE04, 3,       2,      0};
        vt[8]  = '{1'b1, 1'b0, 32'h30, 4'b0000, 32'hFFFFFFFF, 32'h0,        3,       0,      0};
        vt[9]  = '{1'b0, 1'b1, 32'h30, 4'b0000, 32'h0,        32'hDE02BE04, 3,       2,      0};
        vt[10] = '{1'b0, 1'b1, 32'h40, 4'b0000, 32'h0,        32'h33334444, 3,       2,      0};
        vt[11] = '{1'b0, 1'b1, 32'h40, 4'b0000, 32'h0,        32'h33334444, HIT_LAT, HIT_CE, 0};
        vt[12] = '{1'b1, 1'b0, 32'h40, 4'b1111, 32'hCAFEF00D, 32'h0,        3,       2,      2};
        vt[13] = '{1'b0, 1'b1, 32'h43, 4'b0000, 32'h0,        32'hCAFEF00D, 3,       2,      0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ce_n", 32'(ce_n), 32'd1);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_ublb_n", 32'({ub_n, lb_n}), 32'd3);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        check("rst_if_data", mc_if_data, 32'd0);
        check("rst_ready", 32'({mc_if_ready, mc_mem_ready}), 32'd0);
        check("rst_sram_data_z", {31'd0, sram_data === 16'hzzzz}, 32'd1);
        check("rst_mem_data_z", {31'd0, mem_mc_data === 32'hzzzz_zzzz}, 32'd1);
        sram_init = 1'b0;
        reset = 1'b1;

        for (int i = 0; i < 14; i++) run_req(vt[i], $sformatf("v%0d", i));

        // Fetch and data read raised together
        @(negedge clock);
        if_mc_en = 1'b1;
        if_mc_addr = 32'h10;
        mem_mc_en = 1'b1;
        mem_mc_rw = 1'b1;
        mem_mc_addr = 32'h30;
        t = 0;
        tm = 0;
        ti = 0;
        got_m = 1'b0;
        got_i = 1'b0;
        rd_m = '0;
        rd_i = '0;
        while (!got_i && t < 40) begin
            @(posedge clock);
            #1;
            t++;
            if (mc_mem_ready && !got_m) begin
                got_m = 1'b1;
                tm = t;
                rd_m = mem_mc_data;
                mem_mc_en = 1'b0;
            end
            if (mc_if_ready) begin
                got_i = 1'b1;
                ti = t;
                rd_i = mc_if_data;
                if_mc_en = 1'b0;
            end
        end
        check("both_mem_lat", 32'(tm), 32'd3);
        check("both_mem_data", rd_m, 32'hDE02BE04);
        check("both_if_gap", 32'(ti - tm), 32'd4);
        check("both_if_data", rd_i, 32'h12345678);
        @(posedge clock);

        // Three wait states: halves 4 and 5 of the pattern SRAM
        @(negedge clock);
        d3_en = 1'b1;
        d3_addr_in = 32'h8;
        t = 0;
        n_oe = 0;
        seen = 1'b0;
        while (!seen && t < 40) begin
            @(posedge clock);
            #1;
            t++;
            if (!d3_oe) n_oe++;
            seen = d3_mem_ready;
        end
        rd_m = d3_mem_data;
        d3_en = 1'b0;
        check("w3_lat", 32'(t), 32'd7);
        check("w3_oe_cycles", 32'(n_oe), 32'd6);
        check("w3_data", rd_m, 32'h13521353);
        @(posedge clock);

        // Reset dropped during the high half of a write
        @(negedge clock);
        mem_mc_en = 1'b1;
        mem_mc_rw = 1'b0;
        mem_mc_addr = 32'h50;
        {en2h, en2l, en1h, en1l} = 4'b1111;
        tb_wd = 32'h99998888;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_mid_we_before", 32'(we_n), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_we_n", 32'(we_n), 32'd1);
        check("rst_mid_ce_n", 32'(ce_n), 32'd1);
        check("rst_mid_if_data", mc_if_data, 32'd0);
        mem_mc_en = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (mc_mem_ready) seen = 1'b1;
        end
        check("rst_mid_no_ready", 32'(seen), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        vf = '{1'b0, 1'b1, 32'h10, 4'b0000, 32'h0, 32'h12345678, 3, 2, 0};
        run_req(vf, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
